// File: rtl/cpu_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_speed_ctrl
// Purpose  : CPU speed controller for the turbo board. It debounces the
//            multi-bit speed jumper field, holds 7 MHz for a boot interval,
//            and commits a new speed mode only when the CPU bus is idle
//            (S7) and the turbo clock is at a glitch-free phase. It also
//            generates the turbo CPU clock from C100M with a per-mode
//            divider. The top level muxes CLKCPU between C7M
//            (TURBO_EN low) and TURBO_CLK (TURBO_EN high).
// Ports    :
//   C100M        in   1      100 MHz system clock
//   RESET        in   1      asynchronous active-high reset
//   SW_IN        in   SEL_W  raw speed jumper field (asynchronous)
//   FORCE_7M     in   1      synchronous request to hold mode 0
//   AS_CPU_n     in   1      CPU address strobe (asynchronous)
//   DTACK_CPU_n  in   1      combined CPU DTACK (asynchronous)
//   SW_STABLE    out  SEL_W  debounced jumper value
//   BOOT_DONE    out  1      boot interval has elapsed
//   SPEED_MODE   out  SEL_W  committed mode (0 = 7 MHz motherboard clock)
//   TURBO_EN     out  1      SPEED_MODE != 0
//   TURBO_CLK    out  1      divided turbo clock
//   PENDING      out  1      requested mode differs from committed mode
// Revision : 1.0  initial release
// ============================================================================
module cpu_speed_ctrl #(
  parameter int SEL_W        = 2,
  parameter int DEBOUNCE_CYC = 2000000,
  parameter int BOOT_CYC     = 300000000,
  parameter int CNT_W        = 30
) (
  input  logic             C100M,
  input  logic             RESET,
  input  logic [SEL_W-1:0] SW_IN,
  input  logic             FORCE_7M,
  input  logic             AS_CPU_n,
  input  logic             DTACK_CPU_n,
  output logic [SEL_W-1:0] SW_STABLE,
  output logic             BOOT_DONE,
  output logic [SEL_W-1:0] SPEED_MODE,
  output logic             TURBO_EN,
  output logic             TURBO_CLK,
  output logic             PENDING
);

  localparam logic [CNT_W-1:0] c_debounce_cyc = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] c_boot_cyc     = CNT_W'(BOOT_CYC);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam logic [SEL_W-1:0] c_mode_one     = SEL_W'(1);

  // --------------------------------------------------------------------------
  // Input synchronisers
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] r_sw_meta;
  logic [SEL_W-1:0] r_sw_s;
  logic             r_as_meta;
  logic             r_as_s;
  logic             r_dtack_meta;
  logic             r_dtack_s;
  logic             w_idle;

  // Bus strobes reset high so the bus reads as idle straight out of reset.
  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      r_sw_meta    <= '0;
      r_sw_s       <= '0;
      r_as_meta    <= 1'b1;
      r_as_s       <= 1'b1;
      r_dtack_meta <= 1'b1;
      r_dtack_s    <= 1'b1;
    end else begin
      r_sw_meta    <= SW_IN;
      r_sw_s       <= r_sw_meta;
      r_as_meta    <= AS_CPU_n;
      r_as_s       <= r_as_meta;
      r_dtack_meta <= DTACK_CPU_n;
      r_dtack_s    <= r_dtack_meta;
    end
  end

  // S7: both the address strobe and DTACK have been released.
  assign w_idle = r_as_s & r_dtack_s;

  // --------------------------------------------------------------------------
  // Switch debounce
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] r_cand;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] w_db_next;

  // A sample that differs from the candidate restarts the count at 1;
  // otherwise the count extends the current run of identical samples.
  assign w_db_next = (r_sw_s != r_cand) ? c_cnt_one : (r_db_cnt + c_cnt_one);

  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      r_cand    <= '0;
      r_db_cnt  <= '0;
      SW_STABLE <= '0;
    end else if (r_sw_s == SW_STABLE) begin
      r_db_cnt <= '0;
    end else if (w_db_next == c_debounce_cyc) begin
      // The new value has now been seen for DEBOUNCE_CYC consecutive cycles.
      SW_STABLE <= r_sw_s;
      r_cand    <= r_sw_s;
      r_db_cnt  <= '0;
    end else begin
      r_cand   <= r_sw_s;
      r_db_cnt <= w_db_next;
    end
  end

  // --------------------------------------------------------------------------
  // Boot interval
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_boot_cnt;

  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      r_boot_cnt <= '0;
      BOOT_DONE  <= 1'b0;
    end else begin
      if (r_boot_cnt != c_boot_cyc) begin
        r_boot_cnt <= r_boot_cnt + c_cnt_one;
      end
      // Sticky until the next reset.
      if (r_boot_cnt == c_boot_cyc) begin
        BOOT_DONE <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Mode request, commit point and turbo divider
  // --------------------------------------------------------------------------
  logic [SEL_W-1:0] r_hcnt;
  logic [SEL_W-1:0] w_req;
  logic             w_half_end;
  logic             w_fall_pt;
  logic             w_commit;

  assign w_req    = (BOOT_DONE & ~FORCE_7M) ? SW_STABLE : '0;
  assign TURBO_EN = (SPEED_MODE != '0);

  // Last cycle of the current half-period; the compare wraps in mode 0,
  // which is harmless because every user gates it with TURBO_EN.
  assign w_half_end = (r_hcnt == (SPEED_MODE - c_mode_one));

  // The cycle in which TURBO_CLK is about to go high->low.
  assign w_fall_pt = TURBO_EN & TURBO_CLK & w_half_end;

  // Switching only at the falling edge (or from the 7 MHz mode, where
  // TURBO_CLK is parked low) keeps every TURBO_CLK phase at least one full
  // half-period of the old or new mode, so the CLKCPU mux never sees a runt.
  assign w_commit = (w_req != SPEED_MODE) & w_idle & (~TURBO_EN | w_fall_pt);

  always_ff @(posedge C100M or posedge RESET) begin
    if (RESET) begin
      SPEED_MODE <= '0;
      r_hcnt     <= '0;
      TURBO_CLK  <= 1'b0;
      PENDING    <= 1'b0;
    end else begin
      PENDING <= (w_req != SPEED_MODE);
      if (w_commit) begin
        // Start a fresh full low phase of the new mode.
        SPEED_MODE <= w_req;
        r_hcnt     <= '0;
        TURBO_CLK  <= 1'b0;
      end else if (!TURBO_EN) begin
        r_hcnt    <= '0;
        TURBO_CLK <= 1'b0;
      end else if (w_half_end) begin
        r_hcnt    <= '0;
        TURBO_CLK <= ~TURBO_CLK;
      end else begin
        r_hcnt <= r_hcnt + c_mode_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_speed_ctrl
// Purpose  : Directed self-checking bench for cpu_speed_ctrl with
//            DEBOUNCE_CYC = 4, BOOT_CYC = 20, SEL_W = 2.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_speed_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] sw_in;
  logic       force_7m;
  logic       as_n;
  logic       dtack_n;
  logic [1:0] sw_stable;
  logic       boot_done;
  logic [1:0] speed_mode;
  logic       turbo_en;
  logic       turbo_clk;
  logic       pending;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_speed_ctrl #(
    .SEL_W        (2),
    .DEBOUNCE_CYC (4),
    .BOOT_CYC     (20),
    .CNT_W        (8)
  ) dut (
    .C100M       (clk),
    .RESET       (rst),
    .SW_IN       (sw_in),
    .FORCE_7M    (force_7m),
    .AS_CPU_n    (as_n),
    .DTACK_CPU_n (dtack_n),
    .SW_STABLE   (sw_stable),
    .BOOT_DONE   (boot_done),
    .SPEED_MODE  (speed_mode),
    .TURBO_EN    (turbo_en),
    .TURBO_CLK   (turbo_clk),
    .PENDING     (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Tick until SPEED_MODE reaches m or max ticks elapse; lat = ticks taken.
  task automatic wait_mode(input string tag, input logic [1:0] m, input int max, output int lat);
    lat = 0;
    while (speed_mode !== m && lat < max) begin
      tick();
      lat++;
    end
    chk(tag, 32'(speed_mode), 32'(m));
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_sw_stable"}, 32'(sw_stable), 32'd0);
    chk({tag, "_boot_done"}, 32'(boot_done), 32'd0);
    chk({tag, "_speed_mode"}, 32'(speed_mode), 32'd0);
    chk({tag, "_turbo_en"}, 32'(turbo_en), 32'd0);
    chk({tag, "_turbo_clk"}, 32'(turbo_clk), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic       prev_clk;
    logic [5:0] pat2;
    logic [6:0] pat3;

    // ---------------- Reset, boot, first commit to mode 2 ----------------
    rst      = 1'b1;
    sw_in    = 2'd2;
    force_7m = 1'b0;
    as_n     = 1'b1;
    dtack_n  = 1'b1;
    tick();
    tick();
    chk_all_reset("rst0");
    rst = 1'b0;

    repeat (20) tick();
    chk("boot_edge20", 32'(boot_done), 32'd0);
    chk("sw_stable_boot", 32'(sw_stable), 32'd2);
    tick();
    chk("boot_edge21", 32'(boot_done), 32'd1);
    chk("mode_edge21", 32'(speed_mode), 32'd0);
    tick();
    chk("mode_edge22", 32'(speed_mode), 32'd2);
    chk("ten_edge22", 32'(turbo_en), 32'd1);
    chk("tclk_edge22", 32'(turbo_clk), 32'd0);
    chk("pend_edge22", 32'(pending), 32'd1);
    // Edges 23..28: low, high, high, low, low, high
    pat2 = 6'b100110;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mode2_wave", 32'(turbo_clk), 32'(pat2[i]));
    end
    chk("pend_settled", 32'(pending), 32'd0);

    // ---------------- Short glitch is rejected ----------------
    sw_in = 2'd3;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 2) sw_in = 2'd2;
      chk("glitch_stable", 32'(sw_stable), 32'd2);
      chk("glitch_pend", 32'(pending), 32'd0);
    end

    // ---------------- Mode 1, then busy bus blocks change to 3 ----------------
    sw_in = 2'd1;
    wait_mode("to_mode1", 2'd1, 20, lat);
    chk("mode1_wave0", 32'(turbo_clk), 32'd0);
    tick();
    chk("mode1_wave1", 32'(turbo_clk), 32'd1);
    tick();
    chk("mode1_wave2", 32'(turbo_clk), 32'd0);
    tick();
    chk("mode1_wave3", 32'(turbo_clk), 32'd1);

    as_n = 1'b0;
    repeat (3) tick();
    sw_in = 2'd3;
    repeat (10) tick();
    chk("busy_sw_stable", 32'(sw_stable), 32'd3);
    chk("busy_pend", 32'(pending), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_as_mode", 32'(speed_mode), 32'd1);
    end
    as_n    = 1'b1;
    dtack_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_dtack_mode", 32'(speed_mode), 32'd1);
      chk("busy_dtack_pend", 32'(pending), 32'd1);
    end
    dtack_n = 1'b1;
    wait_mode("to_mode3", 2'd3, 8, lat);
    chk("mode3_lat_ok", 32'((lat == 3) || (lat == 4)), 32'd1);
    // From the commit edge: three low, three high, then low.
    pat3 = 7'b0111000;
    chk("mode3_wave0", 32'(turbo_clk), 32'(pat3[0]));
    for (int i = 1; i < 7; i++) begin
      tick();
      chk("mode3_wave", 32'(turbo_clk), 32'(pat3[i]));
    end

    // ---------------- FORCE_7M drops to mode 0 at the fall point ----------------
    force_7m = 1'b1;
    prev_clk = 1'b0;
    lat      = 0;
    while (speed_mode !== 2'd0 && lat < 8) begin
      prev_clk = turbo_clk;
      tick();
      lat++;
    end
    chk("force_mode0", 32'(speed_mode), 32'd0);
    chk("force_ten", 32'(turbo_en), 32'd0);
    chk("force_tclk", 32'(turbo_clk), 32'd0);
    chk("force_at_fall", 32'(prev_clk), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("force_hold_tclk", 32'(turbo_clk), 32'd0);
      chk("force_hold_mode", 32'(speed_mode), 32'd0);
    end
    force_7m = 1'b0;
    tick();
    chk("unforce_mode3", 32'(speed_mode), 32'd3);
    chk("unforce_tclk", 32'(turbo_clk), 32'd0);

    // ---------------- Reset mid-turbo in mode 2 ----------------
    sw_in = 2'd2;
    wait_mode("to_mode2", 2'd2, 24, lat);
    for (int i = 0; i < 4 && turbo_clk !== 1'b1; i++) tick();
    chk("pre_rst_tclk", 32'(turbo_clk), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_reset("rst_async");
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("reboot_edge20", 32'(boot_done), 32'd0);
    tick();
    chk("reboot_edge21", 32'(boot_done), 32'd1);
    tick();
    chk("reboot_mode", 32'(speed_mode), 32'd2);

    // ---------------- Candidate restart on mid-count change ----------------
    sw_in = 2'd0;
    wait_mode("to_mode0", 2'd0, 20, lat);
    repeat (4) tick();
    chk("restart_pre", 32'(sw_stable), 32'd0);
    sw_in = 2'd1;
    tick();
    tick();
    sw_in = 2'd2;
    repeat (4) tick();
    chk("restart_q6", 32'(sw_stable), 32'd0);
    tick();
    chk("restart_q7", 32'(sw_stable), 32'd0);
    tick();
    chk("restart_q8", 32'(sw_stable), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
